// File: rtl/wta_pkg.sv
// Shared types and helpers for the winner-take-all spike generator.
// State encoding plus one-hot decode helpers with lowest-set-bit priority.
package wta_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FIRE    = 2'd1,
        ST_REFRACT = 2'd2
    } state_t;

    function automatic logic [1:0] onehot4_to_bin(input logic [3:0] v);
        logic [1:0] b;
        b = 2'd0;
        if (v[0])      b = 2'd0;
        else if (v[1]) b = 2'd1;
        else if (v[2]) b = 2'd2;
        else if (v[3]) b = 2'd3;
        return b;
    endfunction

    function automatic logic [3:0] lowest_onehot4(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

endpackage

// File: rtl/wta_spike_gen_if.sv
// Comparator-result input, spike/inhibit outputs and counter readout of the WTA stage.
// master drives the comparator side; slave is the spike generator.
interface wta_spike_gen_if #(
    parameter int p_width = 19,
    parameter int p_cnt_w = 8
);
    logic               i_valid;
    logic [p_width-1:0] i_result;
    logic [3:0]         i_index;
    logic [p_width-1:0] i_threshold;
    logic               i_clr_cnt;
    logic [1:0]         i_cnt_sel;
    logic [3:0]         o_spike;
    logic               o_inhibit;
    logic [1:0]         o_winner;
    logic               o_busy;
    logic               o_drop;
    logic [p_cnt_w-1:0] o_cnt;

    modport master (
        output i_valid, i_result, i_index, i_threshold, i_clr_cnt, i_cnt_sel,
        input  o_spike, o_inhibit, o_winner, o_busy, o_drop, o_cnt
    );

    modport slave (
        input  i_valid, i_result, i_index, i_threshold, i_clr_cnt, i_cnt_sel,
        output o_spike, o_inhibit, o_winner, o_busy, o_drop, o_cnt
    );
endinterface

// File: rtl/wta_spike_gen_sat_counter.sv
// Saturating up-counter, one edge per update; clr dominates inc.
// No backpressure: inc beyond the maximum value is absorbed.
module sat_counter #(
    parameter int p_cnt_w = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               inc,
    input  logic               clr,
    output logic [p_cnt_w-1:0] count
);
    logic [p_cnt_w-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc && (count_q != {p_cnt_w{1'b1}}))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) count_q <= '0;
        else          count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/wta_spike_gen.sv
// WTA firing stage: valid at edge N gives a one-cycle spike+inhibit in cycle N+1, then refractory.
// No buffering: valids arriving while busy are discarded and flagged on o_drop one cycle later.
module wta_spike_gen
    import wta_pkg::*;
#(
    parameter int p_width  = 19,
    parameter int p_refrac = 4,
    parameter int p_cnt_w  = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    wta_spike_gen_if.slave bus
);
    localparam int P_RC_W = (p_refrac > 1) ? $clog2(p_refrac) : 1;
    localparam logic [P_RC_W-1:0] RC_LOAD = (p_refrac > 0) ? P_RC_W'(p_refrac - 1) : '0;

    state_t              state_q, state_d;
    logic [P_RC_W-1:0]   refrac_q, refrac_d;
    logic [3:0]          spike_q, spike_d;
    logic [1:0]          winner_q, winner_d;
    logic                drop_q, drop_d;
    logic [p_width-1:0]  result, threshold;
    logic                busy, fire_cond;
    logic [3:0]          inc;
    logic [p_cnt_w-1:0]  cnt [4];

    assign result    = bus.i_result;
    assign threshold = bus.i_threshold;
    assign busy      = (state_q != ST_IDLE);
    assign fire_cond = bus.i_valid && (bus.i_index != 4'd0) && (result >= threshold);

    always_comb begin
        state_d  = state_q;
        refrac_d = refrac_q;
        spike_d  = spike_q;
        winner_d = winner_q;
        drop_d   = bus.i_valid && busy;
        case (state_q)
            ST_IDLE: begin
                if (fire_cond) begin
                    state_d  = ST_FIRE;
                    spike_d  = lowest_onehot4(bus.i_index);
                    winner_d = onehot4_to_bin(bus.i_index);
                end
            end
            ST_FIRE: begin
                if (p_refrac == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d  = ST_REFRACT;
                    refrac_d = RC_LOAD;
                end
            end
            ST_REFRACT: begin
                if (refrac_q == '0) state_d  = ST_IDLE;
                else                refrac_d = refrac_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            refrac_q <= '0;
            spike_q  <= 4'd0;
            winner_q <= 2'd0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            refrac_q <= refrac_d;
            spike_q  <= spike_d;
            winner_q <= winner_d;
            drop_q   <= drop_d;
        end
    end

    // The counter bumps on the edge that closes the FIRE cycle.
    assign inc = (state_q == ST_FIRE) ? spike_q : 4'd0;

    for (genvar k = 0; k < 4; k++) begin : g_cnt
        sat_counter #(.p_cnt_w(p_cnt_w)) u_cnt (
            .i_clk  (i_clk),
            .i_rst_n(i_rst_n),
            .inc    (inc[k]),
            .clr    (bus.i_clr_cnt),
            .count  (cnt[k])
        );
    end

    assign bus.o_spike   = (state_q == ST_FIRE) ? spike_q : 4'd0;
    assign bus.o_inhibit = (state_q == ST_FIRE);
    assign bus.o_winner  = winner_q;
    assign bus.o_busy    = busy;
    assign bus.o_drop    = drop_q;
    assign bus.o_cnt     = cnt[bus.i_cnt_sel];
endmodule

// File: tb/tb_wta_spike_gen.sv
// Scoreboard bench for wta_spike_gen: stimulus queues expected spikes/drops, monitor pops them.
module tb_wta_spike_gen;
    localparam int W = 19;
    localparam int CW = 2;

    typedef struct {
        logic [3:0] spike;
        logic [1:0] winner;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sp_q[$];
    int   drop_q[$];

    wta_spike_gen_if #(.p_width(W), .p_cnt_w(CW)) bus();

    wta_spike_gen #(.p_width(W), .p_refrac(4), .p_cnt_w(CW)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every spike or drop the DUT presents must match a queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_spike != 4'd0 || bus.o_inhibit) begin
                if (sp_q.size() == 0) begin
                    check("unexpected_spike", {27'd0, bus.o_inhibit, bus.o_spike}, 32'd0);
                end else begin
                    exp_t e;
                    e = sp_q.pop_front();
                    check("spike", {27'd0, bus.o_inhibit, bus.o_spike}, {27'd0, 1'b1, e.spike});
                    check("winner", {30'd0, bus.o_winner}, {30'd0, e.winner});
                end
            end
            if (bus.o_drop) begin
                if (drop_q.size() == 0) check("unexpected_drop", 32'd1, 32'd0);
                else begin
                    void'(drop_q.pop_front());
                    check("drop", {31'd0, bus.o_drop}, 32'd1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [W-1:0] res, input logic [3:0] idx);
        bus.i_result = res;
        bus.i_index  = idx;
        bus.i_valid  = 1'b1;
        tick();
        bus.i_valid  = 1'b0;
    endtask

    task automatic expect_spike(input logic [3:0] sp, input logic [1:0] w);
        exp_t e;
        e.spike  = sp;
        e.winner = w;
        sp_q.push_back(e);
    endtask

    task automatic check_cnt(input logic [1:0] sel, input logic [CW-1:0] exp, input string name);
        tick();
        bus.i_cnt_sel = sel;
        #1;
        check(name, {30'd0, bus.o_cnt}, {30'd0, exp});
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            if (!bus.o_busy) break;
            tick();
        end
        check("wait_idle", {31'd0, bus.o_busy}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_result = '0;
        bus.i_index = 4'd0;
        bus.i_threshold = '0;
        bus.i_clr_cnt = 1'b0;
        bus.i_cnt_sel = 2'd0;
        #2;
        check("rst_spike", {28'd0, bus.o_spike}, 32'd0);
        check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
        check("rst_winner", {30'd0, bus.o_winner}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;

        // 1: idle for 10 cycles
        repeat (10) tick();
        check("idle_out", {22'd0, bus.o_spike, bus.o_inhibit, bus.o_winner, bus.o_busy, bus.o_drop}, 32'd0);
        for (int s = 0; s < 4; s++) check_cnt(2'(s), '0, "idle_cnt");

        // 2: equality crossing fires neuron 2, busy for 5 cycles
        bus.i_threshold = 19'd1000;
        expect_spike(4'b0100, 2'd2);
        pulse(19'd1000, 4'b0100);
        check("t2_inhibit", {31'd0, bus.o_inhibit}, 32'd1);
        check("t2_winner", {30'd0, bus.o_winner}, 32'd2);
        for (int c = 0; c < 5; c++) begin
            check("t2_busy", {31'd0, bus.o_busy}, 32'd1);
            tick();
        end
        check("t2_busy_fall", {31'd0, bus.o_busy}, 32'd0);
        check("t2_winner_hold", {30'd0, bus.o_winner}, 32'd2);
        check_cnt(2'd2, 2'd1, "t2_cnt2");

        // 3: below threshold and zero index do nothing
        pulse(19'd999, 4'b0001);
        check("t3_sub_busy", {31'd0, bus.o_busy}, 32'd0);
        pulse(19'd5000, 4'b0000);
        check("t3_zero_busy", {31'd0, bus.o_busy}, 32'd0);
        repeat (2) tick();
        check("t3_drop", {31'd0, bus.o_drop}, 32'd0);

        // 4: valid during refractory is dropped, later accepted
        expect_spike(4'b0001, 2'd0);
        pulse(19'd2000, 4'b0001);
        tick();
        drop_q.push_back(1);
        pulse(19'd2000, 4'b1000);
        check("t4_drop", {31'd0, bus.o_drop}, 32'd1);
        wait_idle();
        check_cnt(2'd3, 2'd0, "t4_cnt3_unchanged");
        expect_spike(4'b1000, 2'd3);
        pulse(19'd2000, 4'b1000);
        wait_idle();
        check_cnt(2'd3, 2'd1, "t4_cnt3");

        // 5: saturation at 3, then clear coincident with a FIRE
        for (int n = 0; n < 5; n++) begin
            expect_spike(4'b0010, 2'd1);
            pulse(19'd1500, 4'b0010);
            wait_idle();
        end
        check_cnt(2'd1, 2'd3, "t5_sat");
        expect_spike(4'b0010, 2'd1);
        pulse(19'd1500, 4'b0010);
        bus.i_clr_cnt = 1'b1;
        tick();
        bus.i_clr_cnt = 1'b0;
        check_cnt(2'd1, 2'd0, "t5_clr1");
        check_cnt(2'd0, 2'd0, "t5_clr0");
        wait_idle();

        // 6: async reset mid-refractory, then malformed index
        expect_spike(4'b0100, 2'd2);
        pulse(19'd3000, 4'b0100);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", {31'd0, bus.o_busy}, 32'd0);
        check("t6_rst_winner", {30'd0, bus.o_winner}, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (8) tick();
        check("t6_idle_busy", {31'd0, bus.o_busy}, 32'd0);
        check_cnt(2'd2, 2'd0, "t6_cnt_reset");
        expect_spike(4'b0010, 2'd1);
        pulse(19'd2000, 4'b1010);
        check("t6_malformed_winner", {30'd0, bus.o_winner}, 32'd1);
        wait_idle();

        repeat (4) tick();
        check("spike_q_empty", sp_q.size(), 32'd0);
        check("drop_q_empty", drop_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
